// File: rtl/shift_share_ctrl.sv
// Two-requester round-robin front end for one shared log shifter.
// Define SHIFT_SHARE_ROTATE_EN to make op 11 a rotate right.
module shift_share_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   req0_valid,
  output logic                   req0_ready,
  input  logic [1:0]             req0_op,
  input  logic [DATA_WIDTH-1:0]  req0_data,
  input  logic [SHAMT_WIDTH-1:0] req0_shamt,
  output logic                   rsp0_valid,
  input  logic                   rsp0_ready,
  output logic [DATA_WIDTH-1:0]  rsp0_data,
  input  logic                   req1_valid,
  output logic                   req1_ready,
  input  logic [1:0]             req1_op,
  input  logic [DATA_WIDTH-1:0]  req1_data,
  input  logic [SHAMT_WIDTH-1:0] req1_shamt,
  output logic                   rsp1_valid,
  input  logic                   rsp1_ready,
  output logic [DATA_WIDTH-1:0]  rsp1_data,
  output logic                   busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                 state;
  logic                   rr_ptr;
  logic                   owner;
  logic [1:0]             op_q;
  logic [DATA_WIDTH-1:0]  data_q;
  logic [SHAMT_WIDTH-1:0] shamt_q;
  logic [DATA_WIDTH-1:0]  shift_res;
  logic                   any_req;
  logic                   grant;
  logic                   rsp_take;

  assign any_req = req0_valid | req1_valid;
  assign grant   = (req0_valid & req1_valid) ? rr_ptr : req1_valid;

  assign req0_ready = (state == IDLE) & any_req & ~grant;
  assign req1_ready = (state == IDLE) & any_req & grant;
  assign busy       = (state != IDLE);
  assign rsp_take   = owner ? rsp1_ready : rsp0_ready;

  // One mux level per shamt bit: 1, 2, 4, 8, 16.
  always_comb begin
    shift_res = data_q;
    for (int i = 0; i < SHAMT_WIDTH; i++) begin
      if (shamt_q[i]) begin
        case (op_q)
          2'b01: shift_res = shift_res >> (1 << i);
          2'b10: shift_res = $signed(shift_res) >>> (1 << i);
`ifdef SHIFT_SHARE_ROTATE_EN
          2'b11: shift_res = (shift_res >> (1 << i)) |
                             (shift_res << (DATA_WIDTH - (1 << i)));
`endif
          default: shift_res = shift_res << (1 << i);
        endcase
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      rr_ptr     <= 1'b0;
      owner      <= 1'b0;
      op_q       <= '0;
      data_q     <= '0;
      shamt_q    <= '0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_data  <= '0;
      rsp1_data  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_req) begin
            op_q    <= grant ? req1_op    : req0_op;
            data_q  <= grant ? req1_data  : req0_data;
            shamt_q <= grant ? req1_shamt : req0_shamt;
            owner   <= grant;
            rr_ptr  <= ~grant;
            state   <= EXEC;
          end
        end
        EXEC: begin
          if (owner) begin
            rsp1_data  <= shift_res;
            rsp1_valid <= 1'b1;
          end else begin
            rsp0_data  <= shift_res;
            rsp0_valid <= 1'b1;
          end
          state <= RESP;
        end
        RESP: begin
          if (rsp_take) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_share_ctrl.sv
// Directed bench for shift_share_ctrl.
// Build with SHIFT_SHARE_ROTATE_EN to check the rotate variant of op 11.
module tb_shift_share_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready;
  logic [1:0]  req0_op;
  logic [31:0] req0_data;
  logic [4:0]  req0_shamt;
  logic        rsp0_valid, rsp0_ready;
  logic [31:0] rsp0_data;
  logic        req1_valid, req1_ready;
  logic [1:0]  req1_op;
  logic [31:0] req1_data;
  logic [4:0]  req1_shamt;
  logic        rsp1_valid, rsp1_ready;
  logic [31:0] rsp1_data;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  shift_share_ctrl dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_op(req0_op), .req0_data(req0_data),
    .req0_shamt(req0_shamt),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_data(rsp0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_op(req1_op), .req1_data(req1_data),
    .req1_shamt(req1_shamt),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_data(rsp1_data),
    .busy(busy)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic run_cmd(input bit who, input logic [1:0] op,
                         input logic [31:0] d, input logic [4:0] sh,
                         output logic [31:0] res);
    int n;
    res = 'x;
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    if (who) begin
      req1_op = op; req1_data = d; req1_shamt = sh; req1_valid = 1'b1;
    end else begin
      req0_op = op; req0_data = d; req0_shamt = sh; req0_valid = 1'b1;
    end
    n = 0;
    while (!(who ? req1_ready : req0_ready) && n < 8) begin
      tick(); n++;
    end
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    n = 0;
    while (!(who ? rsp1_valid : rsp0_valid) && n < 8) begin
      tick(); n++;
    end
    if (who ? rsp1_valid : rsp0_valid)
      res = who ? rsp1_data : rsp0_data;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 ||
        rsp0_data !== 32'h0 || rsp1_data !== 32'h0 || req0_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_state busy=%b v0=%b v1=%b d0=%h d1=%h r0=%b",
               busy, rsp0_valid, rsp1_valid, rsp0_data, rsp1_data, req0_ready);
    end
    reset = 1'b0;
    tick();
    req0_op = 2'b00; req0_data = 32'h1; req0_shamt = 5'd4;
    req0_valid = 1'b1;
    rsp0_ready = 1'b0;
    #1;
    checks++;
    if (req0_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_accept req0_ready=%b want 1", req0_ready);
    end
    tick();
    req0_valid = 1'b0;
    tick();
    checks++;
    if (rsp0_valid !== 1'b1 || rsp0_data !== 32'h10) begin
      errors++;
      $display("FAIL reset_pre_resp v=%b d=%h want 1 00000010",
               rsp0_valid, rsp0_data);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (rsp0_valid !== 1'b0 || busy !== 1'b0 || rsp0_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_resp v=%b busy=%b d=%h want 0 0 0",
               rsp0_valid, busy, rsp0_data);
    end
    #1 reset = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || rsp0_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle busy=%b v=%b want 0 0", busy, rsp0_valid);
    end
  endtask

  task automatic test_single_then_concurrent();
    int lat;
    req0_op = 2'b00; req0_data = 32'h1; req0_shamt = 5'd4;
    req0_valid = 1'b1;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_grant r0=%b r1=%b want 1 0", req0_ready, req1_ready);
    end
    tick();
    req0_valid = 1'b0;
    lat = 1;
    checks++;
    if (busy !== 1'b1 || rsp0_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_exec busy=%b v=%b want 1 0", busy, rsp0_valid);
    end
    while (!rsp0_valid && lat < 10) begin
      tick(); lat++;
    end
    checks++;
    if (lat !== 2 || rsp0_data !== 32'h10 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_resp lat=%0d d=%h busy=%b want 2 00000010 1",
               lat, rsp0_data, busy);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || rsp0_valid !== 1'b0 || rsp0_data !== 32'h10) begin
      errors++;
      $display("FAIL single_done busy=%b v=%b d=%h want 0 0 00000010",
               busy, rsp0_valid, rsp0_data);
    end
    req0_op = 2'b01; req0_data = 32'h8000_0000; req0_shamt = 5'd31;
    req1_op = 2'b10; req1_data = 32'h8000_0000; req1_shamt = 5'd31;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    checks++;
    if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
      errors++;
      $display("FAIL rr_grant r0=%b r1=%b want 0 1", req0_ready, req1_ready);
    end
    tick();
    req1_valid = 1'b0;
    checks++;
    if (req0_ready !== 1'b0) begin
      errors++;
      $display("FAIL exec_ready r0=%b want 0", req0_ready);
    end
    tick();
    checks++;
    if (rsp1_valid !== 1'b1 || rsp1_data !== 32'hFFFF_FFFF ||
        rsp0_valid !== 1'b0 || req0_ready !== 1'b0) begin
      errors++;
      $display("FAIL rr_first v1=%b d1=%h v0=%b r0=%b want 1 ffffffff 0 0",
               rsp1_valid, rsp1_data, rsp0_valid, req0_ready);
    end
    tick();
    checks++;
    if (req0_ready !== 1'b1) begin
      errors++;
      $display("FAIL rr_second_grant r0=%b want 1", req0_ready);
    end
    tick();
    req0_valid = 1'b0;
    tick();
    checks++;
    if (rsp0_valid !== 1'b1 || rsp0_data !== 32'h1 || rsp1_valid !== 1'b0) begin
      errors++;
      $display("FAIL rr_second v0=%b d0=%h v1=%b want 1 00000001 0",
               rsp0_valid, rsp0_data, rsp1_valid);
    end
    tick();
  endtask

  task automatic test_backpressure();
    bit bad;
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b1;
    req0_op = 2'b00; req0_data = 32'h3; req0_shamt = 5'd1;
    req0_valid = 1'b1;
    tick();
    req0_valid = 1'b0;
    req1_op = 2'b01; req1_data = 32'h10; req1_shamt = 5'd4;
    req1_valid = 1'b1;
    tick();
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (rsp0_valid !== 1'b1 || rsp0_data !== 32'h6 || req1_ready !== 1'b0)
        bad = 1'b1;
      tick();
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL backpressure_hold v0=%b d0=%h r1=%b want 1 00000006 0",
               rsp0_valid, rsp0_data, req1_ready);
    end
    rsp0_ready = 1'b1;
    tick();
    checks++;
    if (req1_ready !== 1'b1 || rsp0_valid !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_release r1=%b v0=%b want 1 0",
               req1_ready, rsp0_valid);
    end
    tick();
    req1_valid = 1'b0;
    tick();
    checks++;
    if (rsp1_valid !== 1'b1 || rsp1_data !== 32'h1) begin
      errors++;
      $display("FAIL backpressure_next v1=%b d1=%h want 1 00000001",
               rsp1_valid, rsp1_data);
    end
    tick();
  endtask

  task automatic test_ops();
    logic [31:0] r;
    logic [31:0] exp_t [4];
    logic [1:0]  op_t  [4];
    logic [31:0] dat_t [4];
    logic [4:0]  sh_t  [4];
    op_t[0] = 2'b00; dat_t[0] = 32'h3;         sh_t[0] = 5'd31; exp_t[0] = 32'h8000_0000;
    op_t[1] = 2'b01; dat_t[1] = 32'hFFFF_FFFF; sh_t[1] = 5'd31; exp_t[1] = 32'h1;
    op_t[2] = 2'b10; dat_t[2] = 32'h7000_0000; sh_t[2] = 5'd4;  exp_t[2] = 32'h0700_0000;
    op_t[3] = 2'b10; dat_t[3] = 32'h9000_0000; sh_t[3] = 5'd8;  exp_t[3] = 32'hFF90_0000;
    for (int i = 0; i < 4; i++) begin
      run_cmd(i[0], op_t[i], dat_t[i], sh_t[i], r);
      checks++;
      if (r !== exp_t[i]) begin
        errors++;
        $display("FAIL ops_%0d got=%h want=%h", i, r, exp_t[i]);
      end
    end
  endtask

  task automatic test_shamt0_hold();
    logic [31:0] r;
    for (int i = 0; i < 3; i++) begin
      run_cmd(i[0], 2'(i), 32'hA5A5_5A5A, 5'd0, r);
      checks++;
      if (r !== 32'hA5A5_5A5A) begin
        errors++;
        $display("FAIL shamt0_op%0d got=%h want=a5a55a5a", i, r);
      end
    end
    rsp0_ready = 1'b1;
    req0_op = 2'b01; req0_data = 32'hF000_0000; req0_shamt = 5'd4;
    req0_valid = 1'b1;
    tick();
    req0_valid = 1'b0;
    req0_data = 32'hFFFF_FFFF; req0_shamt = 5'd0; req0_op = 2'b00;
    tick();
    checks++;
    if (rsp0_valid !== 1'b1 || rsp0_data !== 32'h0F00_0000) begin
      errors++;
      $display("FAIL operand_hold v=%b got=%h want 1 0f000000",
               rsp0_valid, rsp0_data);
    end
    tick();
  endtask

  task automatic test_op11();
    logic [31:0] r;
    logic [31:0] exp;
`ifdef SHIFT_SHARE_ROTATE_EN
    exp = 32'hF000_0000;
`else
    exp = 32'h0000_00F0;
`endif
    run_cmd(1'b1, 2'b11, 32'h0000_000F, 5'd4, r);
    checks++;
    if (r !== exp) begin
      errors++;
      $display("FAIL op11 got=%h want=%h", r, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    req0_valid = 1'b0; req0_op = '0; req0_data = '0; req0_shamt = '0;
    req1_valid = 1'b0; req1_op = '0; req1_data = '0; req1_shamt = '0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    test_reset();
    test_single_then_concurrent();
    test_backpressure();
    test_ops();
    test_shamt0_hold();
    test_op11();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
